// File: rtl/channel_byte_packer_pkg.sv
// channel_byte_packer_pkg: shared defaults, channel index width and output FSM states
package channel_byte_packer_pkg;
  localparam int DEF_NUM_CHANNELS = 7;
  localparam int DEF_SAMPLE_BITS = 8;
  localparam int CH_IDX_W = 3;
  typedef enum logic {IDLE, SEND} state_t;
endpackage

// File: rtl/channel_byte_packer_if.sv
// channel_byte_packer_if: sample capture inputs plus the valid/ready packed-byte stream
interface channel_byte_packer_if import channel_byte_packer_pkg::*; #(
  parameter int NUM_CHANNELS = DEF_NUM_CHANNELS,
  parameter int SAMPLE_BITS = DEF_SAMPLE_BITS
);
  logic sample_valid;
  logic [NUM_CHANNELS-1:0] sample_in;
  logic [SAMPLE_BITS-1:0] byte_data;
  logic [CH_IDX_W-1:0] byte_channel;
  logic byte_valid;
  logic byte_ready;
  logic frame_start;
  logic overflow;
  logic clear_overflow;
  modport master (
    input sample_valid, sample_in, byte_ready, clear_overflow,
    output byte_data, byte_channel, byte_valid, frame_start, overflow
  );
  modport slave (
    output sample_valid, sample_in, byte_ready, clear_overflow,
    input byte_data, byte_channel, byte_valid, frame_start, overflow
  );
endinterface

// File: rtl/channel_byte_packer_sample_deserializer.sv
// sample_deserializer: one channel's shift register; word_o is the value including the current bit
module sample_deserializer import channel_byte_packer_pkg::*; #(
  parameter int SAMPLE_BITS = DEF_SAMPLE_BITS
) (
  input  logic clk,
  input  logic reset,
  input  logic shift_i,
  input  logic bit_i,
  output logic [SAMPLE_BITS-1:0] word_o
);
  logic [SAMPLE_BITS-1:0] sr_q;
  assign word_o = {sr_q[SAMPLE_BITS-2:0], bit_i};
  // shift in one bit per qualified sample, first sample drifts to the MSB
  always_ff @(posedge clk)
    if (reset) sr_q <= '0;
    else if (shift_i) sr_q <= word_o;
endmodule

// File: rtl/channel_byte_packer.sv
// channel_byte_packer: packs 8 samples per channel into bytes and drains them through a one-frame hold
module channel_byte_packer import channel_byte_packer_pkg::*; #(
  parameter int NUM_CHANNELS = DEF_NUM_CHANNELS,
  parameter int SAMPLE_BITS = DEF_SAMPLE_BITS
) (
  input logic clk,
  input logic reset,
  channel_byte_packer_if.master bus
);
  localparam int CW = $clog2(SAMPLE_BITS);
  localparam logic [CW-1:0] LAST_BIT = CW'(SAMPLE_BITS - 1);
  localparam logic [CH_IDX_W-1:0] LAST_CH = CH_IDX_W'(NUM_CHANNELS - 1);
  state_t state_q, state_d;
  logic [CH_IDX_W-1:0] idx_q, idx_d, chan_q;
  logic [CW-1:0] cnt_q;
  logic [SAMPLE_BITS-1:0] word [NUM_CHANNELS];
  logic [SAMPLE_BITS-1:0] hold_q [NUM_CHANNELS];
  logic [SAMPLE_BITS-1:0] hold_d [NUM_CHANNELS];
  logic [SAMPLE_BITS-1:0] data_q;
  logic valid_q, fs_q, ovf_q;
  logic frame_done, accept, last_acc, load;
  for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_des
    sample_deserializer #(.SAMPLE_BITS(SAMPLE_BITS)) u_des (
      .clk(clk),
      .reset(reset),
      .shift_i(bus.sample_valid),
      .bit_i(bus.sample_in[i]),
      .word_o(word[i])
    );
  end
  assign frame_done = bus.sample_valid && cnt_q == LAST_BIT;
  assign accept = valid_q && bus.byte_ready;
  assign last_acc = accept && idx_q == LAST_CH;
  assign load = frame_done && (state_q == IDLE || last_acc);
  // hold is full exactly while SEND; a new frame lands when empty or as the last byte leaves
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    hold_d = hold_q;
    if (load) begin
      state_d = SEND;
      idx_d = '0;
      hold_d = word;
    end else if (accept) begin
      state_d = last_acc ? IDLE : SEND;
      idx_d = last_acc ? '0 : idx_q + 1'b1;
    end
  end
  // state, sample counter, hold buffer and registered byte-stream outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q <= '0;
      cnt_q <= '0;
      hold_q <= '{default: '0};
      valid_q <= 1'b0;
      data_q <= '0;
      chan_q <= '0;
      fs_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      hold_q <= hold_d;
      if (bus.sample_valid) cnt_q <= frame_done ? '0 : cnt_q + 1'b1;
      valid_q <= state_d == SEND;
      data_q <= state_d == SEND ? hold_d[idx_d] : '0;
      chan_q <= idx_d;
      fs_q <= state_d == SEND && idx_d == '0;
      ovf_q <= (frame_done && !load) || (ovf_q && !bus.clear_overflow);
    end
  end
  assign bus.byte_valid = valid_q;
  assign bus.byte_data = data_q;
  assign bus.byte_channel = chan_q;
  assign bus.frame_start = fs_q;
  assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_channel_byte_packer.sv
// tb_channel_byte_packer: directed stimulus checked against a queue-level byte model
module tb_channel_byte_packer;
  import channel_byte_packer_pkg::*;
  localparam int NCH = 7;
  localparam int SB = 8;
  typedef struct {logic [2:0] ch; logic [7:0] d;} exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int vectors = 0;
  int errors = 0;
  bit started = 1'b0;
  exp_t exp_q[$];
  logic bits_m [NCH][SB];
  int n_m = 0;
  logic ovf_m = 1'b0;
  channel_byte_packer_if #(.NUM_CHANNELS(NCH), .SAMPLE_BITS(SB)) bus ();
  channel_byte_packer #(.NUM_CHANNELS(NCH), .SAMPLE_BITS(SB)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.master)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask
  // model: a frame is a list of 7 bytes; it is queued only if the queue is empty or its last byte leaves now
  always @(posedge clk) begin
    int sz;
    bit acc;
    exp_t e;
    started <= 1'b1;
    if (reset) begin
      exp_q.delete();
      n_m = 0;
      ovf_m = 1'b0;
    end else begin
      sz = exp_q.size();
      acc = sz > 0 && bus.byte_ready;
      if (acc) void'(exp_q.pop_front());
      if (bus.clear_overflow) ovf_m = 1'b0;
      if (bus.sample_valid) begin
        for (int c = 0; c < NCH; c++) bits_m[c][n_m] = bus.sample_in[c];
        n_m++;
        if (n_m == SB) begin
          n_m = 0;
          if (sz == 0 || (sz == 1 && acc)) begin
            for (int c = 0; c < NCH; c++) begin
              e.ch = 3'(c);
              e.d = '0;
              for (int k = 0; k < SB; k++) e.d = e.d | (8'(bits_m[c][k]) << (SB - 1 - k));
              exp_q.push_back(e);
            end
          end else ovf_m = 1'b1;
        end
      end
    end
  end
  // compare DUT outputs with the model away from the active edge
  always @(negedge clk) if (started) begin
    check("byte_valid", 32'(bus.byte_valid), 32'(exp_q.size() != 0));
    check("overflow", 32'(bus.overflow), 32'(ovf_m));
    if (exp_q.size() != 0) begin
      check("byte_channel", 32'(bus.byte_channel), 32'(exp_q[0].ch));
      check("byte_data", 32'(bus.byte_data), 32'(exp_q[0].d));
      check("frame_start", 32'(bus.frame_start), 32'(exp_q[0].ch == 3'd0));
    end else check("frame_start_idle", 32'(bus.frame_start), 32'd0);
  end
  task automatic cyc(input logic sv, input logic [NCH-1:0] si, input logic rdy, input logic clr);
    bus.sample_valid = sv;
    bus.sample_in = si;
    bus.byte_ready = rdy;
    bus.clear_overflow = clr;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset(input int n);
    reset = 1'b1;
    for (int i = 0; i < n; i++) cyc(1'b1, 7'h7F, 1'b1, 1'b0);
    reset = 1'b0;
  endtask
  function automatic logic [NCH-1:0] pat(input int k, input logic [7:0] c0);
    logic [4:0] mid;
    mid = 5'(k * 7 + 3);
    return {1'b1, mid, c0[7-k]};
  endfunction
  task automatic feed_frame(input logic [7:0] c0, input logic rdy, input bit gap, input logic clr_last);
    for (int k = 0; k < SB; k++) begin
      if (gap && k > 0) cyc(1'b0, 7'h55, rdy, 1'b0);
      cyc(1'b1, pat(k, c0), rdy, clr_last && k == SB - 1);
    end
  endtask
  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, rdy, 1'b0);
  endtask
  initial begin
    bus.sample_valid = 1'b1;
    bus.sample_in = 7'h7F;
    bus.byte_ready = 1'b1;
    bus.clear_overflow = 1'b0;
    do_reset(2);
    check("rst_valid", 32'(bus.byte_valid), 32'd0);
    check("rst_overflow", 32'(bus.overflow), 32'd0);
    check("rst_channel", 32'(bus.byte_channel), 32'd0);
    check("rst_data", 32'(bus.byte_data), 32'd0);
    for (int i = 0; i < 7; i++) begin
      cyc(1'b1, 7'h2A, 1'b1, 1'b0);
      check("rst_no_byte", 32'(bus.byte_valid), 32'd0);
    end
    do_reset(1);
    feed_frame(8'hA5, 1'b1, 1'b0, 1'b0);
    check("pack_ch0_valid", 32'(bus.byte_valid), 32'd1);
    check("pack_ch0_chan", 32'(bus.byte_channel), 32'd0);
    check("pack_ch0_data", 32'(bus.byte_data), 32'hA5);
    check("pack_ch0_fs", 32'(bus.frame_start), 32'd1);
    for (int c = 1; c < NCH; c++) begin
      idle(1, 1'b1);
      check("pack_seq_chan", 32'(bus.byte_channel), 32'(c));
    end
    check("pack_ch6_data", 32'(bus.byte_data), 32'hFF);
    idle(1, 1'b1);
    check("pack_done", 32'(bus.byte_valid), 32'd0);
    feed_frame(8'h3C, 1'b1, 1'b0, 1'b0);
    idle(3, 1'b1);
    for (int i = 0; i < 5; i++) begin
      idle(1, 1'b0);
      check("bp_hold_chan", 32'(bus.byte_channel), 32'd3);
      check("bp_hold_valid", 32'(bus.byte_valid), 32'd1);
    end
    idle(1, 1'b1);
    check("bp_next_chan", 32'(bus.byte_channel), 32'd4);
    idle(3, 1'b1);
    check("bp_done", 32'(bus.byte_valid), 32'd0);
    feed_frame(8'h81, 1'b0, 1'b0, 1'b0);
    feed_frame(8'h18, 1'b0, 1'b0, 1'b0);
    check("ovf_set", 32'(bus.overflow), 32'd1);
    check("ovf_keep_a", 32'(bus.byte_data), 32'h81);
    idle(7, 1'b1);
    check("ovf_drained", 32'(bus.byte_valid), 32'd0);
    cyc(1'b0, '0, 1'b1, 1'b1);
    check("ovf_cleared", 32'(bus.overflow), 32'd0);
    feed_frame(8'h11, 1'b0, 1'b0, 1'b0);
    feed_frame(8'h22, 1'b0, 1'b0, 1'b1);
    check("ovf_set_wins", 32'(bus.overflow), 32'd1);
    cyc(1'b0, '0, 1'b0, 1'b1);
    check("ovf_cleared2", 32'(bus.overflow), 32'd0);
    idle(8, 1'b1);
    feed_frame(8'hC3, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < SB; k++) cyc(1'b1, pat(k, 8'h5A), k != 0, 1'b0);
    check("bnd_no_ovf", 32'(bus.overflow), 32'd0);
    check("bnd_valid", 32'(bus.byte_valid), 32'd1);
    check("bnd_chan", 32'(bus.byte_channel), 32'd0);
    check("bnd_fs", 32'(bus.frame_start), 32'd1);
    check("bnd_data", 32'(bus.byte_data), 32'h5A);
    idle(8, 1'b1);
    feed_frame(8'hA5, 1'b1, 1'b1, 1'b0);
    check("gap_ch0_data", 32'(bus.byte_data), 32'hA5);
    idle(6, 1'b1);
    check("gap_ch6_data", 32'(bus.byte_data), 32'hFF);
    idle(2, 1'b1);
    for (int k = 0; k < 4; k++) cyc(1'b1, 7'h01, 1'b1, 1'b0);
    do_reset(1);
    feed_frame(8'h96, 1'b1, 1'b0, 1'b0);
    check("mrst_ch0_data", 32'(bus.byte_data), 32'h96);
    idle(8, 1'b1);
    check("final_idle", 32'(bus.byte_valid), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
